// File: rtl/tdm_mux_8_1.sv
// tdm_mux_8_1: round-robin 8:1 gathering multiplexer.
// Picks one of eight valid/ready producers per cycle and holds the selected
// beat, tagged with its channel index, in a single output register.
module tdm_mux_8_1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Enable_In,
  input  logic [8*DATA_WIDTH-1:0] Data_In,
  input  logic [7:0]              Valid_In,
  output logic [7:0]              Ready_Out,
  output logic [DATA_WIDTH-1:0]   Data_Out,
  output logic [2:0]              Select_Out,
  output logic                    Valid_Out,
  input  logic                    Ready_In,
  output logic [15:0]             Transfer_Count_Out
);

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [2:0]            sel_p0;
  logic [2:0]            pointer;
  logic [15:0]           xfer_cnt;

  logic                  load_en;
  logic                  grant;
  logic [2:0]            grant_idx;
  logic                  any_valid;
  logic [2:0]            pick_idx;

  // First requesting channel at or after the pointer, wrapping modulo 8.
  // Scanning from the farthest offset down leaves the nearest hit last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] sel;
    sel = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  // Arbitration: grant only when the output slot is free or draining now.
  always_comb begin
    load_en   = !vld_p0 || Ready_In;
    any_valid = |Valid_In;
    pick_idx  = rr_pick(Valid_In, pointer);
    grant     = load_en && Enable_In && any_valid && !Reset_In;
    grant_idx = pick_idx;
    Ready_Out = 8'd0;
    if (grant) Ready_Out[grant_idx] = 1'b1;
  end

  // Stage p0: output beat register, round-robin pointer and transfer counter.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      sel_p0   <= 3'd0;
      pointer  <= 3'd0;
      xfer_cnt <= 16'd0;
    end else begin
      if (vld_p0 && Ready_In) xfer_cnt <= xfer_cnt + 16'd1;
      if (grant) begin
        vld_p0  <= 1'b1;
        data_p0 <= Data_In[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_p0  <= grant_idx;
        pointer <= grant_idx + 3'd1;
      end else if (load_en) begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign Valid_Out          = vld_p0;
  assign Data_Out           = data_p0;
  assign Select_Out         = sel_p0;
  assign Transfer_Count_Out = xfer_cnt;

endmodule
